// File: rtl/pipe_datapath_memory.sv
// Memory stage of the RV32I pipeline: issues load/store transactions on a
// req/ack data bus, lane-replicates store data, aligns and extends load data,
// stalls the pipeline while a transaction is outstanding and aborts hung
// transactions after TIMEOUT cycles.
`ifndef XLEN
`define XLEN 32
`endif

module pipe_datapath_memory #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [`XLEN-1:0]   i_dp_ALUM,
    input  logic [`XLEN-1:0]   i_dp_WriteDataM,
    input  logic [2:0]         i_dp_funct3M,
    input  logic               i_dp_MemWriteM,
    input  logic               i_dp_MemReadM,
    input  logic               i_dp_FlushM,
    output logic               o_dmem_req,
    output logic               o_dmem_we,
    output logic [`XLEN-1:0]   o_dmem_addr,
    output logic [`XLEN-1:0]   o_dmem_wdata,
    output logic [3:0]         o_dmem_be,
    input  logic               i_dmem_ack,
    input  logic [`XLEN-1:0]   i_dmem_rdata,
    output logic [`XLEN-1:0]   o_dp_ReadDataM,
    output logic               o_dp_StallM,
    output logic               o_dp_MisalignM,
    output logic               o_dp_BusErrM
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              buserr_q, buserr_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              access;
    logic              size_b;
    logic              size_h;
    logic              misaligned;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new;
    logic              stall;

    // Pick a byte/halfword out of the returned word and extend it; unlisted
    // funct3 encodings fall through to a full-word load.
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    // Decode access width, alignment, byte enables and replicated store data.
    always_comb begin
        access     = (i_dp_MemReadM | i_dp_MemWriteM) & ~i_dp_FlushM;
        size_b     = (i_dp_funct3M == 3'b000) || (i_dp_funct3M == 3'b100);
        size_h     = (i_dp_funct3M == 3'b001) || (i_dp_funct3M == 3'b101);
        misaligned = size_b ? 1'b0 : (size_h ? i_dp_ALUM[0] : (i_dp_ALUM[1:0] != 2'b00));
        be_new     = 4'b1111;
        wdata_new  = i_dp_WriteDataM;
        if (i_dp_MemWriteM) begin
            if (size_b) begin
                be_new    = 4'b0001 << i_dp_ALUM[1:0];
                wdata_new = {4{i_dp_WriteDataM[7:0]}};
            end else if (size_h) begin
                be_new    = 4'b0011 << {i_dp_ALUM[1], 1'b0};
                wdata_new = {2{i_dp_WriteDataM[15:0]}};
            end
        end
    end

    // Next-state and bus/result register updates for the IDLE/BUSY/DONE FSM.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        f3_d     = f3_q;
        off_d    = off_q;
        rdata_d  = rdata_q;
        buserr_d = 1'b0;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && !misaligned) begin
                    stall   = 1'b1;
                    we_d    = i_dp_MemWriteM;
                    addr_d  = {i_dp_ALUM[31:2], 2'b00};
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    f3_d    = i_dp_funct3M;
                    off_d   = i_dp_ALUM[1:0];
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (i_dmem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = load_extract(i_dmem_rdata, f3_q, off_q);
                    end
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    req_d    = 1'b0;
                    rdata_d  = '0;
                    buserr_d = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and bus registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            f3_q     <= '0;
            off_q    <= '0;
            rdata_q  <= '0;
            buserr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            rdata_q  <= rdata_d;
            buserr_q <= buserr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_dmem_req     = req_q;
    assign o_dmem_we      = we_q;
    assign o_dmem_addr    = addr_q;
    assign o_dmem_wdata   = wdata_q;
    assign o_dmem_be      = be_q;
    assign o_dp_ReadDataM = rdata_q;
    assign o_dp_StallM    = stall;
    assign o_dp_MisalignM = (state_q == IDLE) && access && misaligned;
    assign o_dp_BusErrM   = buserr_q;

endmodule
